// File: rtl/matrix_result_serializer.sv
// Streams a captured DIM x DIM signed matrix one element per valid/ready beat, row-major, MSB element first.
// Optional macro MATRIX_SER_OVF_SKIP_EN: an overflowed capture skips streaming and goes straight to done.
module matrix_result_serializer #(
  parameter  int DIM    = 5,
  parameter  int ELEM_W = 8,
  parameter  int ADDR_W = 5,
  localparam int MAT_W  = DIM * DIM * ELEM_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [MAT_W-1:0]  mat_in,
  input  logic              ovf_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ELEM_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              ovf_flag
);

  localparam int N = DIM * DIM;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_DONE
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              capture;
  logic              advance;
  logic [MAT_W-1:0]  shift_reg;
  logic [ADDR_W-1:0] idx;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    advance   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          capture = 1'b1;
`ifdef MATRIX_SER_OVF_SKIP_EN
          state_nxt = ovf_in ? S_DONE : S_SEND;
`else
          state_nxt = S_SEND;
`endif
        end
      end
      S_SEND: begin
        if (out_ready) begin
          advance = 1'b1;
          if (idx == LAST_IDX) state_nxt = S_DONE;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Index returns to 0 after the last beat so out_addr never leaves 0..N-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_reg <= '0;
      idx       <= '0;
      ovf_flag  <= 1'b0;
    end else if (capture) begin
      shift_reg <= mat_in;
      idx       <= '0;
      ovf_flag  <= ovf_in;
    end else if (advance) begin
      shift_reg <= {shift_reg[MAT_W-ELEM_W-1:0], {ELEM_W{1'b0}}};
      idx       <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
    end
  end

  assign out_valid = (state == S_SEND);
  assign out_data  = shift_reg[MAT_W-1 -: ELEM_W];
  assign out_addr  = idx;
  assign out_last  = (state == S_SEND) && (idx == LAST_IDX);
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);

endmodule
